// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: streams parser bytes onto scan-in, collects scan-out into bytes,
// drives the CSOC scan clock / scan-enable and can issue a single capture pulse.
module scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 1919,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CNT_W     = 12
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_start_i,
  input  logic       cmd_op_i,
  input  logic       abort_i,
  output logic       busy_o,
  output logic       done_o,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  input  logic       out_ready_i,
  output logic       scan_clk_o,
  output logic       scan_se_o,
  output logic       scan_si_o,
  input  logic       scan_so_i
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] ChainLen = CNT_W'(CHAIN_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShLo,
    StShHi,
    StEmit,
    StCapLo,
    StCapHi,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] bit_cnt_inc;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       nxt_idx;
  logic [7:0]       in_sr_q, in_sr_d;
  logic [7:0]       out_sr_q, out_sr_d;
  logic             si_q, si_d;
  logic             div_last;

  logic busy_q, done_q, in_ready_q, out_valid_q, scan_clk_q, scan_se_q;

  assign div_last    = (div_q == DivLast);
  assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);
  assign nxt_idx     = bit_idx_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    in_sr_d   = in_sr_q;
    out_sr_d  = out_sr_q;
    si_d      = si_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_start_i) begin
          bit_cnt_d = '0;
          div_d     = '0;
          state_d   = cmd_op_i ? StCapLo : StLoad;
        end
      end
      StLoad: begin
        if (in_valid_i && in_ready_q) begin
          in_sr_d   = in_data_i;
          out_sr_d  = '0;
          bit_idx_d = '0;
          div_d     = '0;
          si_d      = in_data_i[0];
          state_d   = StShLo;
        end
      end
      StShLo: begin
        if (div_last) begin
          // Sample before the rising edge we are about to generate.
          out_sr_d[bit_idx_q] = scan_so_i;
          div_d               = '0;
          state_d             = StShHi;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StShHi: begin
        if (div_last) begin
          div_d     = '0;
          bit_cnt_d = bit_cnt_inc;
          bit_idx_d = nxt_idx;
          if (bit_idx_q == 3'd7 || bit_cnt_inc == ChainLen) begin
            state_d = StEmit;
          end else begin
            si_d    = in_sr_q[nxt_idx];
            state_d = StShLo;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StEmit: begin
        if (out_valid_q && out_ready_i) begin
          state_d = (bit_cnt_q == ChainLen) ? StDone : StLoad;
        end
      end
      StCapLo: begin
        if (div_last) begin
          div_d   = '0;
          state_d = StCapHi;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StCapHi: begin
        if (div_last) begin
          div_d   = '0;
          state_d = StDone;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StDone: begin
        si_d    = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides any handshake seen in the same cycle.
    if (abort_i && state_q != StIdle) begin
      state_d   = StIdle;
      div_d     = '0;
      bit_cnt_d = '0;
      si_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      in_sr_q     <= '0;
      out_sr_q    <= '0;
      si_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      scan_clk_q  <= 1'b0;
      scan_se_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      in_sr_q     <= in_sr_d;
      out_sr_q    <= out_sr_d;
      si_q        <= si_d;
      // Outputs decode the next state so they are registered yet aligned with the state.
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
      in_ready_q  <= (state_d == StLoad);
      out_valid_q <= (state_d == StEmit);
      scan_clk_q  <= (state_d == StShHi) || (state_d == StCapHi);
      scan_se_q   <= (state_d == StLoad) || (state_d == StShLo) ||
                     (state_d == StShHi) || (state_d == StEmit);
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_sr_q;
  assign scan_clk_o  = scan_clk_q;
  assign scan_se_o   = scan_se_q;
  assign scan_si_o   = si_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two instances (16-flop/CLK_DIV=1, 11-flop/CLK_DIV=2) driving
// behavioural chain models, with a byte scoreboard on the scan-out stream.
module tb_scan_chain_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] start, op, abort, busy, done, in_valid, in_ready, out_valid, out_ready;
  logic [1:0] sclk, se, si, so;
  logic [7:0] in_data [2];
  logic [7:0] out_data0, out_data1;

  logic [15:0] chain0;
  logic [10:0] chain1;
  int edges0 = 0, edges1 = 0, se_edges0 = 0, se_edges1 = 0, done_cnt0 = 0, done_cnt1 = 0;
  int n_pass = 0, n_total = 0;
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  scan_chain_ctrl #(.CHAIN_LEN(16), .CLK_DIV(1), .CNT_W(5)) u_dut16 (
    .clk(clk), .rstn(rstn), .cmd_start_i(start[0]), .cmd_op_i(op[0]), .abort_i(abort[0]),
    .busy_o(busy[0]), .done_o(done[0]), .in_valid_i(in_valid[0]), .in_data_i(in_data[0]),
    .in_ready_o(in_ready[0]), .out_valid_o(out_valid[0]), .out_data_o(out_data0),
    .out_ready_i(out_ready[0]), .scan_clk_o(sclk[0]), .scan_se_o(se[0]), .scan_si_o(si[0]),
    .scan_so_i(so[0])
  );

  scan_chain_ctrl #(.CHAIN_LEN(11), .CLK_DIV(2), .CNT_W(4)) u_dut11 (
    .clk(clk), .rstn(rstn), .cmd_start_i(start[1]), .cmd_op_i(op[1]), .abort_i(abort[1]),
    .busy_o(busy[1]), .done_o(done[1]), .in_valid_i(in_valid[1]), .in_data_i(in_data[1]),
    .in_ready_o(in_ready[1]), .out_valid_o(out_valid[1]), .out_data_o(out_data1),
    .out_ready_i(out_ready[1]), .scan_clk_o(sclk[1]), .scan_se_o(se[1]), .scan_si_o(si[1]),
    .scan_so_i(so[1])
  );

  // Chain models: shift on scan_clk rise when se=1, hold on a capture pulse.
  assign so[0] = chain0[15];
  assign so[1] = chain1[10];

  always @(posedge sclk[0]) begin
    edges0++;
    if (se[0]) begin
      se_edges0++;
      chain0 = {chain0[14:0], si[0]};
    end
  end

  always @(posedge sclk[1]) begin
    edges1++;
    if (se[1]) begin
      se_edges1++;
      chain1 = {chain1[9:0], si[1]};
    end
  end

  always @(negedge clk) begin
    if (done[0]) done_cnt0++;
    if (done[1]) done_cnt1++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  // Scoreboard monitors: pop one expected byte per accepted scan-out byte.
  always @(negedge clk) begin
    if (rstn && out_valid[0] && out_ready[0]) begin
      if (exp0.size() == 0) begin
        n_total++;
        $display("FAIL sb0_extra: got 0x%0h, required no byte", out_data0);
      end else check("sb0_byte", {24'b0, out_data0}, {24'b0, exp0.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (rstn && out_valid[1] && out_ready[1]) begin
      if (exp1.size() == 0) begin
        n_total++;
        $display("FAIL sb1_extra: got 0x%0h, required no byte", out_data1);
      end else check("sb1_byte", {24'b0, out_data1}, {24'b0, exp1.pop_front()});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input int k, input logic o);
    start[k] = 1'b1;
    op[k]    = o;
    @(negedge clk);
    start[k] = 1'b0;
    op[k]    = 1'b0;
  endtask

  task automatic send_byte(input int k, input logic [7:0] b);
    int n = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = b;
    while (!in_ready[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'b0, in_ready[k]}, 32'd1);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy[k] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {31'b0, busy[k]}, 32'd0);
  endtask

  task automatic run_shift(input int k, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] e0, input logic [7:0] e1, input int len);
    int e, s, d;
    e = (k == 0) ? edges0 : edges1;
    s = (k == 0) ? se_edges0 : se_edges1;
    d = (k == 0) ? done_cnt0 : done_cnt1;
    if (k == 0) begin exp0.push_back(e0); exp0.push_back(e1); end
    else begin exp1.push_back(e0); exp1.push_back(e1); end
    pulse_start(k, 1'b0);
    send_byte(k, b0);
    send_byte(k, b1);
    wait_idle(k);
    check("shift_edges", ((k == 0) ? edges0 : edges1) - e, len);
    check("shift_se_edges", ((k == 0) ? se_edges0 : se_edges1) - s, len);
    check("shift_done", ((k == 0) ? done_cnt0 : done_cnt1) - d, 1);
  endtask

  initial begin
    int e, d, n, bad;
    logic [7:0] held;
    logic [15:0] snap;
    start = '0; op = '0; abort = '0; in_valid = '0; out_ready = 2'b11;
    in_data[0] = '0; in_data[1] = '0;
    chain0 = 16'hFFFF;
    chain1 = '0;
    repeat (3) @(negedge clk);
    check("reset_outs0", {busy[0], done[0], in_ready[0], out_valid[0], sclk[0], se[0], si[0],
                          out_data0}, 32'd0);
    check("reset_outs1", {busy[1], done[1], in_ready[1], out_valid[1], sclk[1], se[1], si[1],
                          out_data1}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // 16-flop chain: preloaded ones come out, then the loaded bytes loop back.
    run_shift(0, 8'hA5, 8'h3C, 8'hFF, 8'hFF, 16);
    run_shift(0, 8'h00, 8'h00, 8'hA5, 8'h3C, 16);

    // Back-pressure during EMIT.
    e = edges0;
    exp0.push_back(8'h00);
    exp0.push_back(8'h00);
    out_ready[0] = 1'b0;
    pulse_start(0, 1'b0);
    send_byte(0, 8'h12);
    n = 0;
    while (!out_valid[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid", {31'b0, out_valid[0]}, 32'd1);
    held = out_data0;
    bad  = 0;
    repeat (20) begin
      @(negedge clk);
      if (sclk[0] !== 1'b0 || out_data0 !== held || out_valid[0] !== 1'b1) bad++;
    end
    check("stall_stable", bad, 0);
    check("stall_edges", edges0 - e, 8);
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    send_byte(0, 8'h34);
    wait_idle(0);
    check("stall_total_edges", edges0 - e, 16);

    // Capture pulse.
    e = edges0; d = se_edges0; snap = chain0;
    n = done_cnt0;
    pulse_start(0, 1'b1);
    bad = 0;
    while (!done[0] && bad < 50) begin
      @(negedge clk);
      bad++;
    end
    check("cap_done", {31'b0, done[0]}, 32'd1);
    check("cap_busy_at_done", {31'b0, busy[0]}, 32'd1);
    @(negedge clk);
    check("cap_done_1cyc", {31'b0, done[0]}, 32'd0);
    check("cap_busy_drop", {31'b0, busy[0]}, 32'd0);
    check("cap_edges", edges0 - e, 1);
    check("cap_se_low", se_edges0 - d, 0);
    check("cap_done_cnt", done_cnt0 - n, 1);
    check("cap_chain_held", {16'b0, chain0}, {16'b0, snap});

    // Abort after 5 edges, with a coincident start that must be ignored.
    e = edges0; d = done_cnt0;
    pulse_start(0, 1'b0);
    send_byte(0, 8'hAA);
    n = 0;
    while (edges0 - e < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_pre_edges", edges0 - e, 5);
    abort[0] = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    start[0] = 1'b0;
    check("abort_outs", {busy[0], sclk[0], se[0], in_ready[0], out_valid[0]}, 32'd0);
    repeat (4) @(negedge clk);
    check("abort_stays_idle", {31'b0, busy[0]}, 32'd0);
    check("abort_no_done", done_cnt0 - d, 0);
    check("abort_edges", edges0 - e, 5);

    chain0 = 16'h0000;
    run_shift(0, 8'h5A, 8'hC3, 8'h00, 8'h00, 16);
    run_shift(0, 8'h00, 8'h00, 8'h5A, 8'hC3, 16);

    // Asynchronous reset in the middle of a shift.
    pulse_start(0, 1'b0);
    send_byte(0, 8'hFF);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midreset_outs", {busy[1], busy[0], done[0], in_ready[0], out_valid[0], sclk[0],
                            se[0], si[0], out_data0}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // 11-flop chain: partial final byte.
    chain1 = '0;
    run_shift(1, 8'hFF, 8'hFF, 8'h00, 8'h00, 11);
    run_shift(1, 8'hFF, 8'hFF, 8'hFF, 8'h07, 11);
    run_shift(1, 8'h00, 8'h00, 8'hFF, 8'h07, 11);

    repeat (4) @(negedge clk);
    check("sb0_drained", exp0.size(), 0);
    check("sb1_drained", exp1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
